// File: rtl/stepper_move_ctrl.sv
// rtl/stepper_move_ctrl.sv - counted, trapezoid-ramped half-step move sequencer
// Drives four unipolar coils from an 8-state phase index that persists across moves.
module stepper_move_ctrl #(
  parameter int PER_W    = 20,
  parameter int STEPS_W  = 16,
  parameter int PER_MAX  = 500000,
  parameter int PER_MIN  = 50000,
  parameter int PER_STEP = 25000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic               cmd_dir,
  input  logic               abort,
  input  logic               hold_en,
  output logic [3:0]         coils,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [STEPS_W-1:0] steps_left,
  output logic [PER_W-1:0]   cur_period
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [PER_W-1:0] P_MAX  = PER_W'(PER_MAX);
  localparam logic [PER_W-1:0] P_MIN  = PER_W'(PER_MIN);
  localparam logic [PER_W:0]   W_MAX  = (PER_W+1)'(PER_MAX);
  localparam logic [PER_W:0]   W_MIN  = (PER_W+1)'(PER_MIN);
  localparam logic [PER_W:0]   W_STEP = (PER_W+1)'(PER_STEP);

  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic                 dir_q, dir_d;
  logic [STEPS_W-1:0]   steps_left_q, steps_left_d;
  logic [STEPS_W-1:0]   ramp_cnt_q, ramp_cnt_d;
  logic [PER_W-1:0]     period_q, period_d;
  logic [PER_W-1:0]     timer_q, timer_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;

  logic                 step_due;
  logic [STEPS_W-1:0]   left_nxt;
  logic [PER_W:0]       per_up, per_dn;
  logic [3:0]           pattern;

  // Saturating period arithmetic is done one bit wider so it can never wrap.
  always_comb begin
    step_due = (timer_q == period_q - PER_W'(1));
    left_nxt = steps_left_q - STEPS_W'(1);
    per_up   = {1'b0, period_q} + W_STEP;
    if (per_up > W_MAX) per_up = W_MAX;
    if ({1'b0, period_q} >= W_MIN + W_STEP) per_dn = {1'b0, period_q} - W_STEP;
    else                                    per_dn = W_MIN;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dir_d        = dir_q;
    steps_left_d = steps_left_q;
    ramp_cnt_d   = ramp_cnt_q;
    period_d     = period_q;
    timer_d      = timer_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          steps_left_d = cmd_steps;
          dir_d        = cmd_dir;
          period_d     = P_MAX;
          ramp_cnt_d   = '0;
          timer_d      = '0;
          aborted_d    = 1'b0;
          if (cmd_steps == '0) done_d  = 1'b1;
          else                 state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (step_due) begin
          timer_d      = '0;
          idx_d        = dir_q ? idx_q + 3'd1 : idx_q - 3'd1;
          steps_left_d = left_nxt;
          if (left_nxt == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (left_nxt <= ramp_cnt_q) begin
            period_d   = per_up[PER_W-1:0];
            ramp_cnt_d = (ramp_cnt_q == '0) ? '0 : ramp_cnt_q - STEPS_W'(1);
          end else if (period_q > P_MIN) begin
            period_d   = per_dn[PER_W-1:0];
            ramp_cnt_d = ramp_cnt_q + STEPS_W'(1);
          end
        end else begin
          timer_d = timer_q + PER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      dir_q        <= 1'b0;
      steps_left_q <= '0;
      ramp_cnt_q   <= '0;
      period_q     <= P_MAX;
      timer_q      <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dir_q        <= dir_d;
      steps_left_q <= steps_left_d;
      ramp_cnt_q   <= ramp_cnt_d;
      period_q     <= period_d;
      timer_q      <= timer_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  always_comb begin
    case (idx_q)
      3'd0:    pattern = 4'b1000;
      3'd1:    pattern = 4'b1100;
      3'd2:    pattern = 4'b0100;
      3'd3:    pattern = 4'b0110;
      3'd4:    pattern = 4'b0010;
      3'd5:    pattern = 4'b0011;
      3'd6:    pattern = 4'b0001;
      default: pattern = 4'b1001;
    endcase
  end

  assign busy       = (state_q == RUN);
  assign cmd_ready  = (state_q == IDLE);
  assign coils      = (busy | hold_en) ? pattern : 4'b0000;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_left = steps_left_q;
  assign cur_period = period_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// tb/tb_stepper_move_ctrl.sv - table-driven and randomized checks of stepper_move_ctrl
// Step-level profile model: intervals derived from the accel/cruise/decel rules per step.
module tb_stepper_move_ctrl;

  localparam int PMAX = 8;
  localparam int PMIN = 4;
  localparam int PSTP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic        abort = 1'b0;
  logic        hold_en = 1'b0;
  logic [3:0]  coils;
  logic        busy, done, aborted;
  logic [15:0] steps_left;
  logic [19:0] cur_period;

  stepper_move_ctrl #(
    .PER_W(20), .STEPS_W(16), .PER_MAX(PMAX), .PER_MIN(PMIN), .PER_STEP(PSTP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .abort(abort), .hold_en(hold_en),
    .coils(coils), .busy(busy), .done(done), .aborted(aborted),
    .steps_left(steps_left), .cur_period(cur_period)
  );

  always #5 clk = ~clk;

  typedef struct {
    int steps;
    bit dir;
    int abort_step;
    bit mid_valid;
    int exp_left;
    bit exp_aborted;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [3:0] pat [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};
  int m_idx = 0;
  int m_int[$];
  int m_per[$];
  int rec[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Interval before each step, and the period in force after it.
  function automatic void model(input int n);
    int per = PMAX;
    int ramp = 0;
    int l;
    m_int.delete();
    m_per.delete();
    for (int s = 0; s < n; s++) begin
      m_int.push_back(per);
      l = n - s - 1;
      if (l > 0) begin
        if (l <= ramp) begin
          per = (per + PSTP > PMAX) ? PMAX : per + PSTP;
          ramp = (ramp > 0) ? ramp - 1 : 0;
        end else if (per > PMIN) begin
          per = (per - PSTP < PMIN) ? PMIN : per - PSTP;
          ramp++;
        end
      end
      m_per.push_back(per);
    end
  endfunction

  task automatic do_move(input int n, input bit dir, input int ab, input bit midv,
                         input int exp_left, input bit exp_ab);
    int cum[$];
    int acc = 0;
    int taken;
    int t = 0;
    int done_t = -1;
    int exp_done;
    int exp_per;
    logic [3:0] prev;
    model(n);
    foreach (m_int[i]) begin
      acc += m_int[i];
      cum.push_back(acc);
    end
    taken    = (ab > 0) ? ab - 1 : n;
    exp_per  = (taken == 0) ? PMAX : m_per[taken-1];
    exp_done = (ab > 0) ? cum[ab-1] : ((n == 0) ? 0 : cum[n-1]);
    rec.delete();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_steps = 16'(n);
    cmd_dir   = dir;
    @(posedge clk);
    #1;
    prev = coils;
    if (done) done_t = 0;
    while (done_t < 0 && t < 3000) begin
      @(negedge clk);
      t++;
      cmd_valid = midv && (t == 3);
      cmd_steps = (midv && t == 3) ? 16'd2 : 16'(n);
      abort     = (ab > 0) && (t == cum[ab-1]);
      @(posedge clk);
      #1;
      if (coils != prev) begin
        rec.push_back(t);
        m_idx = (m_idx + (dir ? 1 : 7)) % 8;
        chk("step_coils", int'(coils), int'(pat[m_idx]));
        prev = coils;
      end
      if (done) done_t = t;
    end
    chk("done_time", done_t, exp_done);
    chk("step_count", rec.size(), taken);
    for (int i = 0; i < taken && i < rec.size(); i++) chk("step_time", rec[i], cum[i]);
    chk("busy_after", int'(busy), 0);
    chk("ready_after", int'(cmd_ready), 1);
    chk("steps_left", int'(steps_left), exp_left);
    chk("aborted", int'(aborted), int'(exp_ab));
    chk("cur_period", int'(cur_period), exp_per);
    @(negedge clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    @(posedge clk);
    #1;
    chk("done_one_cycle", int'(done), 0);
  endtask

  vec_t vecs[6];
  int exp6[6] = '{8, 6, 4, 4, 6, 8};

  initial begin
    vecs[0] = '{steps: 6,  dir: 1'b1, abort_step: 0, mid_valid: 1'b0, exp_left: 0, exp_aborted: 1'b0};
    vecs[1] = '{steps: 1,  dir: 1'b0, abort_step: 0, mid_valid: 1'b0, exp_left: 0, exp_aborted: 1'b0};
    vecs[2] = '{steps: 20, dir: 1'b1, abort_step: 0, mid_valid: 1'b0, exp_left: 0, exp_aborted: 1'b0};
    vecs[3] = '{steps: 10, dir: 1'b1, abort_step: 3, mid_valid: 1'b0, exp_left: 8, exp_aborted: 1'b1};
    vecs[4] = '{steps: 0,  dir: 1'b1, abort_step: 0, mid_valid: 1'b0, exp_left: 0, exp_aborted: 1'b0};
    vecs[5] = '{steps: 7,  dir: 1'b0, abort_step: 0, mid_valid: 1'b1, exp_left: 0, exp_aborted: 1'b0};

    #12;
    chk("rst_coils_nohold", int'(coils), 0);
    hold_en = 1'b1;
    #1;
    chk("rst_coils_hold", int'(coils), 4'b1000);
    hold_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_coils", int'(coils), 0);
    chk("idle_ready", int'(cmd_ready), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_aborted", int'(aborted), 0);
    chk("idle_steps_left", int'(steps_left), 0);
    chk("idle_period", int'(cur_period), PMAX);
    hold_en = 1'b1;
    #1;
    chk("idle_hold_coils", int'(coils), 4'b1000);

    for (int i = 0; i < 6; i++) begin
      if (i == 1) m_idx = 0;
      do_move(vecs[i].steps, vecs[i].dir, vecs[i].abort_step, vecs[i].mid_valid,
              vecs[i].exp_left, vecs[i].exp_aborted);
      if (i == 0) begin
        for (int k = 0; k < 6 && k < rec.size(); k++)
          chk("six_interval", (k == 0) ? rec[0] : rec[k] - rec[k-1], exp6[k]);
        // Return to idx 0 so the reverse single step lands on 1001.
        do_move(2, 1'b1, 0, 1'b0, 0, 1'b0);
        chk("idx_back_coils", int'(coils), 4'b1000);
      end
      if (i == 1) chk("rev_from_zero", int'(coils), 4'b1001);
      if (i == 3) begin
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_abort_aborted", int'(aborted), 1);
        chk("idle_abort_done", int'(done), 0);
        chk("idle_abort_busy", int'(busy), 0);
        chk("idle_abort_left", int'(steps_left), 8);
        @(negedge clk);
        abort = 1'b0;
      end
    end

    for (int r = 0; r < 8; r++) begin
      int n;
      int ab;
      bit d;
      n  = $urandom_range(0, 25);
      d  = 1'($urandom_range(0, 1));
      ab = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
      do_move(n, d, ab, 1'b0, (ab > 0) ? n - (ab - 1) : 0, ab > 0);
    end

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_steps = 16'd10;
    cmd_dir   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_idx = 0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_ready", int'(cmd_ready), 1);
    chk("mid_rst_left", int'(steps_left), 0);
    chk("mid_rst_period", int'(cur_period), PMAX);
    chk("mid_rst_aborted", int'(aborted), 0);
    chk("mid_rst_coils", int'(coils), 4'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    hold_en = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_done", int'(done), 0);
    chk("post_rst_coils", int'(coils), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
